// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: default widths, ALU function codes and the
// control-bit bundle carried from ID through EX and EX/MEM.
package id_ex_pipe_reg_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_ALUFN_W = 4;
  localparam int DEF_PERF_W  = 16;
  localparam int SHAMT_W     = 5;

  typedef enum logic [DEF_ALUFN_W-1:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10
  } alu_fn_e;

  // Bit order is shared with the decoder and EX/MEM; do not reorder.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX stage bundle: decoded ID fields, WB write port, flush/hold controls
// in; registered EX fields, stall and perf counter out.
interface id_ex_pipe_reg_if
  import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int ALUFN_W = DEF_ALUFN_W,
    parameter int PERF_W  = DEF_PERF_W
);
    logic               ID_Valid;
    logic [SHAMT_W-1:0] ID_Shamt;
    logic               ID_ALUSrc1, ID_ALUSrc2;
    logic [DATA_W-1:0]  ID_RsVal, ID_RtVal, ID_Immediate;
    logic [ALUFN_W-1:0] ID_ALUFn;
    logic [RADDR_W-1:0] ID_Rs, ID_Rt, ID_Wr;
    logic               ID_UsesRs, ID_UsesRt;
    logic               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_Branch;
    logic               WB_RegWrite;
    logic [RADDR_W-1:0] WB_Wr;
    logic [DATA_W-1:0]  WB_Data;
    logic               Flush, Hold, Stall;

    logic               EX_Valid;
    logic [SHAMT_W-1:0] EX_Shamt;
    logic               EX_ALUSrc1, EX_ALUSrc2;
    logic [DATA_W-1:0]  EX_RsVal, EX_RtVal, EX_Immediate;
    logic [ALUFN_W-1:0] EX_ALUFn;
    logic [RADDR_W-1:0] EX_Rs, EX_Rt, EX_Wr;
    logic               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_Branch;
    logic [PERF_W-1:0]  BubbleCnt;

    modport master (
        output ID_Valid, ID_Shamt, ID_ALUSrc1, ID_ALUSrc2, ID_RsVal, ID_RtVal, ID_Immediate,
               ID_ALUFn, ID_Rs, ID_Rt, ID_Wr, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead,
               ID_MemWrite, ID_MemToReg, ID_Branch, WB_RegWrite, WB_Wr, WB_Data, Flush, Hold,
        input  Stall, EX_Valid, EX_Shamt, EX_ALUSrc1, EX_ALUSrc2, EX_RsVal, EX_RtVal,
               EX_Immediate, EX_ALUFn, EX_Rs, EX_Rt, EX_Wr, EX_RegWrite, EX_MemRead,
               EX_MemWrite, EX_MemToReg, EX_Branch, BubbleCnt
    );

    modport slave (
        input  ID_Valid, ID_Shamt, ID_ALUSrc1, ID_ALUSrc2, ID_RsVal, ID_RtVal, ID_Immediate,
               ID_ALUFn, ID_Rs, ID_Rt, ID_Wr, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead,
               ID_MemWrite, ID_MemToReg, ID_Branch, WB_RegWrite, WB_Wr, WB_Data, Flush, Hold,
        output Stall, EX_Valid, EX_Shamt, EX_ALUSrc1, EX_ALUSrc2, EX_RsVal, EX_RtVal,
               EX_Immediate, EX_ALUFn, EX_Rs, EX_Rt, EX_Wr, EX_RegWrite, EX_MemRead,
               EX_MemWrite, EX_MemToReg, EX_Branch, BubbleCnt
    );
endinterface

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// Load-use hazard detection: an in-flight load in EX whose destination is a
// live source of the ID instruction. Purely combinational.
module id_ex_pipe_reg_hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic [RADDR_W-1:0] ex_wr,
    input  logic               id_valid,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               hold,
    output logic               load_use,
    output logic               stall
);
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_wr != '0) && id_valid &&
                   ((id_uses_rs && (id_rs == ex_wr)) || (id_uses_rt && (id_rt == ex_wr)));
        stall    = load_use || hold;
    end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use bubble insertion, flush/hold
// handling, same-cycle WB bypass and a saturating bubble counter.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int ALUFN_W = DEF_ALUFN_W,
    parameter int PERF_W  = DEF_PERF_W
) (
    input logic clk,
    input logic rst_n,
    id_ex_pipe_reg_if.slave io
);
    ctrl_t id_ctrl, ex_ctrl;
    logic  load_use, flush_pend;
    logic  hit_id_rs, hit_id_rt, hit_ex_rs, hit_ex_rt;

    function automatic logic wb_hit(input logic we, input logic [RADDR_W-1:0] wr,
                                    input logic [RADDR_W-1:0] idx);
        return we && (wr != '0) && (wr == idx);
    endfunction

    assign hit_id_rs = wb_hit(io.WB_RegWrite, io.WB_Wr, io.ID_Rs);
    assign hit_id_rt = wb_hit(io.WB_RegWrite, io.WB_Wr, io.ID_Rt);
    assign hit_ex_rs = wb_hit(io.WB_RegWrite, io.WB_Wr, io.EX_Rs);
    assign hit_ex_rt = wb_hit(io.WB_RegWrite, io.WB_Wr, io.EX_Rt);

    assign id_ctrl = '{reg_write:  io.ID_RegWrite, mem_read: io.ID_MemRead,
                       mem_write:  io.ID_MemWrite, mem_to_reg: io.ID_MemToReg,
                       branch:     io.ID_Branch};

    assign io.EX_RegWrite = ex_ctrl.reg_write;
    assign io.EX_MemRead  = ex_ctrl.mem_read;
    assign io.EX_MemWrite = ex_ctrl.mem_write;
    assign io.EX_MemToReg = ex_ctrl.mem_to_reg;
    assign io.EX_Branch   = ex_ctrl.branch;

    id_ex_pipe_reg_hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
        .ex_valid   (io.EX_Valid),
        .ex_mem_read(ex_ctrl.mem_read),
        .ex_wr      (io.EX_Wr),
        .id_valid   (io.ID_Valid),
        .id_uses_rs (io.ID_UsesRs),
        .id_uses_rt (io.ID_UsesRt),
        .id_rs      (io.ID_Rs),
        .id_rt      (io.ID_Rt),
        .hold       (io.Hold),
        .load_use   (load_use),
        .stall      (io.Stall)
    );

    // Bubbles only clear valid/control; stale data fields are harmless behind EX_Valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.EX_Valid     <= 1'b0;
            io.EX_Shamt     <= '0;
            io.EX_ALUSrc1   <= 1'b0;
            io.EX_ALUSrc2   <= 1'b0;
            io.EX_RsVal     <= '0;
            io.EX_RtVal     <= '0;
            io.EX_Immediate <= '0;
            io.EX_ALUFn     <= '0;
            io.EX_Rs        <= '0;
            io.EX_Rt        <= '0;
            io.EX_Wr        <= '0;
            ex_ctrl         <= '0;
            flush_pend      <= 1'b0;
            io.BubbleCnt    <= '0;
        end else if (io.Hold) begin
            if (io.Flush) flush_pend <= 1'b1;
            if (hit_ex_rs) io.EX_RsVal <= io.WB_Data;
            if (hit_ex_rt) io.EX_RtVal <= io.WB_Data;
        end else if (io.Flush || flush_pend) begin
            io.EX_Valid <= 1'b0;
            ex_ctrl     <= '0;
            flush_pend  <= 1'b0;
        end else if (load_use) begin
            io.EX_Valid <= 1'b0;
            ex_ctrl     <= '0;
            if (!(&io.BubbleCnt)) io.BubbleCnt <= io.BubbleCnt + 1'b1;
        end else begin
            io.EX_Valid     <= io.ID_Valid;
            io.EX_Shamt     <= io.ID_Shamt;
            io.EX_ALUSrc1   <= io.ID_ALUSrc1;
            io.EX_ALUSrc2   <= io.ID_ALUSrc2;
            io.EX_RsVal     <= hit_id_rs ? io.WB_Data : io.ID_RsVal;
            io.EX_RtVal     <= hit_id_rt ? io.WB_Data : io.ID_RtVal;
            io.EX_Immediate <= io.ID_Immediate;
            io.EX_ALUFn     <= io.ID_ALUFn;
            io.EX_Rs        <= io.ID_Rs;
            io.EX_Rt        <= io.ID_Rt;
            io.EX_Wr        <= io.ID_Wr;
            ex_ctrl         <= io.ID_Valid ? id_ctrl : '0;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios then random traffic against a
// cycle-level reference of the ID->EX register, plus a 2-bit-counter copy.
module tb_id_ex_pipe_reg;
    import id_ex_pipe_reg_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  shamt;
        logic        src1, src2;
        logic [31:0] rsval, rtval, imm;
        logic [3:0]  alufn;
        logic [4:0]  rs, rt, wr;
        logic        regw, memr, memw, m2r, br;
    } ex_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.PERF_W(16)) io ();
    id_ex_pipe_reg_if #(.PERF_W(2))  io_s ();

    id_ex_pipe_reg #(.PERF_W(16)) dut   (.clk(clk), .rst_n(rst_n), .io(io));
    id_ex_pipe_reg #(.PERF_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .io(io_s));

    assign io_s.ID_Valid = io.ID_Valid;         assign io_s.ID_Shamt = io.ID_Shamt;
    assign io_s.ID_ALUSrc1 = io.ID_ALUSrc1;     assign io_s.ID_ALUSrc2 = io.ID_ALUSrc2;
    assign io_s.ID_RsVal = io.ID_RsVal;         assign io_s.ID_RtVal = io.ID_RtVal;
    assign io_s.ID_Immediate = io.ID_Immediate; assign io_s.ID_ALUFn = io.ID_ALUFn;
    assign io_s.ID_Rs = io.ID_Rs;               assign io_s.ID_Rt = io.ID_Rt;
    assign io_s.ID_Wr = io.ID_Wr;               assign io_s.ID_UsesRs = io.ID_UsesRs;
    assign io_s.ID_UsesRt = io.ID_UsesRt;       assign io_s.ID_RegWrite = io.ID_RegWrite;
    assign io_s.ID_MemRead = io.ID_MemRead;     assign io_s.ID_MemWrite = io.ID_MemWrite;
    assign io_s.ID_MemToReg = io.ID_MemToReg;   assign io_s.ID_Branch = io.ID_Branch;
    assign io_s.WB_RegWrite = io.WB_RegWrite;   assign io_s.WB_Wr = io.WB_Wr;
    assign io_s.WB_Data = io.WB_Data;           assign io_s.Flush = io.Flush;
    assign io_s.Hold = io.Hold;

    int   checks = 0;
    int   errors = 0;
    ex_t  m;          // what EX should hold
    bit   fp;         // flush remembered across a hold
    int   cnt;        // load-use bubbles since reset, unbounded
    logic last_stall;
    ex_t  saved;

    task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic ex_t obs();
        ex_t o;
        o.valid = io.EX_Valid;   o.shamt = io.EX_Shamt;
        o.src1 = io.EX_ALUSrc1;  o.src2 = io.EX_ALUSrc2;
        o.rsval = io.EX_RsVal;   o.rtval = io.EX_RtVal;  o.imm = io.EX_Immediate;
        o.alufn = io.EX_ALUFn;   o.rs = io.EX_Rs;  o.rt = io.EX_Rt;  o.wr = io.EX_Wr;
        o.regw = io.EX_RegWrite; o.memr = io.EX_MemRead; o.memw = io.EX_MemWrite;
        o.m2r = io.EX_MemToReg;  o.br = io.EX_Branch;
        return o;
    endfunction

    function automatic bit wb_writes(input logic [4:0] idx);
        return io.WB_RegWrite && io.WB_Wr != 0 && io.WB_Wr == idx;
    endfunction

    function automatic ex_t bubble(input ex_t e);
        ex_t b = e;
        b.valid = 0; b.regw = 0; b.memr = 0; b.memw = 0; b.m2r = 0; b.br = 0;
        return b;
    endfunction

    task automatic model_reset();
        m = '0; fp = 0; cnt = 0;
    endtask

    task automatic idle();
        io.ID_Valid = 0; io.ID_Shamt = 0; io.ID_ALUSrc1 = 0; io.ID_ALUSrc2 = 0;
        io.ID_RsVal = 0; io.ID_RtVal = 0; io.ID_Immediate = 0; io.ID_ALUFn = ALU_ADD;
        io.ID_Rs = 0; io.ID_Rt = 0; io.ID_Wr = 0; io.ID_UsesRs = 0; io.ID_UsesRt = 0;
        io.ID_RegWrite = 0; io.ID_MemRead = 0; io.ID_MemWrite = 0; io.ID_MemToReg = 0;
        io.ID_Branch = 0; io.WB_RegWrite = 0; io.WB_Wr = 0; io.WB_Data = 0;
        io.Flush = 0; io.Hold = 0;
    endtask

    // Small register range so hazards and bypass hits happen often.
    task automatic rand_inputs();
        io.ID_Valid = ($urandom_range(0, 9) < 8);
        io.ID_Shamt = 5'($urandom_range(0, 31));
        io.ID_ALUSrc1 = ($urandom_range(0, 1) == 1); io.ID_ALUSrc2 = ($urandom_range(0, 1) == 1);
        io.ID_RsVal = $urandom(); io.ID_RtVal = $urandom(); io.ID_Immediate = $urandom();
        io.ID_ALUFn = 4'($urandom_range(0, 15));
        io.ID_Rs = 5'($urandom_range(0, 3)); io.ID_Rt = 5'($urandom_range(0, 3));
        io.ID_Wr = 5'($urandom_range(0, 3));
        io.ID_UsesRs = ($urandom_range(0, 3) != 0); io.ID_UsesRt = ($urandom_range(0, 1) == 1);
        io.ID_RegWrite = ($urandom_range(0, 1) == 1); io.ID_MemRead = ($urandom_range(0, 9) < 4);
        io.ID_MemWrite = ($urandom_range(0, 1) == 1); io.ID_MemToReg = ($urandom_range(0, 1) == 1);
        io.ID_Branch = ($urandom_range(0, 1) == 1);
        io.WB_RegWrite = ($urandom_range(0, 1) == 1); io.WB_Wr = 5'($urandom_range(0, 3));
        io.WB_Data = $urandom();
        io.Flush = ($urandom_range(0, 9) == 0); io.Hold = ($urandom_range(0, 6) == 0);
    endtask

    // Called just after an edge with inputs applied: checks Stall, advances the
    // reference by one clock and checks the registered outputs.
    task automatic step();
        bit lu;
        #1;
        lu = m.valid && m.memr && m.wr != 0 && io.ID_Valid &&
             ((io.ID_UsesRs && io.ID_Rs == m.wr) || (io.ID_UsesRt && io.ID_Rt == m.wr));
        last_stall = io.Stall;
        chk("stall", io.Stall, lu || io.Hold);
        if (io.Hold) begin
            if (io.Flush) fp = 1;
            if (wb_writes(m.rs)) m.rsval = io.WB_Data;
            if (wb_writes(m.rt)) m.rtval = io.WB_Data;
        end else if (io.Flush || fp) begin
            m = bubble(m); fp = 0;
        end else if (lu) begin
            m = bubble(m); cnt++;
        end else begin
            m.valid = io.ID_Valid; m.shamt = io.ID_Shamt;
            m.src1 = io.ID_ALUSrc1; m.src2 = io.ID_ALUSrc2;
            m.rsval = wb_writes(io.ID_Rs) ? io.WB_Data : io.ID_RsVal;
            m.rtval = wb_writes(io.ID_Rt) ? io.WB_Data : io.ID_RtVal;
            m.imm = io.ID_Immediate; m.alufn = io.ID_ALUFn;
            m.rs = io.ID_Rs; m.rt = io.ID_Rt; m.wr = io.ID_Wr;
            m.regw = io.ID_Valid && io.ID_RegWrite; m.memr = io.ID_Valid && io.ID_MemRead;
            m.memw = io.ID_Valid && io.ID_MemWrite; m.m2r = io.ID_Valid && io.ID_MemToReg;
            m.br = io.ID_Valid && io.ID_Branch;
        end
        @(posedge clk);
        #1;
        if (m.valid) chk("ex_rec", obs(), m);
        else chk("ex_bubble", {io.EX_Valid, io.EX_RegWrite, io.EX_MemRead, io.EX_MemWrite,
                               io.EX_MemToReg, io.EX_Branch}, 6'b0);
        chk("bubble_cnt", io.BubbleCnt, sat(cnt, 65535));
        chk("bubble_cnt_w2", io_s.BubbleCnt, sat(cnt, 3));
    endtask

    task automatic load_in_ex(input logic [4:0] wr);
        idle(); io.ID_Valid = 1; io.ID_Rs = 1; io.ID_UsesRs = 1; io.ID_Wr = wr;
        io.ID_MemRead = 1; io.ID_RegWrite = 1; io.ID_MemToReg = 1; io.ID_Immediate = 32'h10;
        step();
    endtask

    task automatic dependent_add(input logic [4:0] rs);
        idle(); io.ID_Valid = 1; io.ID_Rs = rs; io.ID_UsesRs = 1; io.ID_Rt = 2;
        io.ID_UsesRt = 1; io.ID_Wr = 9; io.ID_RegWrite = 1; io.ID_ALUFn = ALU_ADD;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex", obs(), ex_t'(0));
        chk("rst_cnt", io.BubbleCnt, 0);
        rst_n = 1;

        // Load-use: lw r8 then add using r8 -> one bubble, then the add enters.
        load_in_ex(5'd8);
        dependent_add(5'd8); step();
        chk("lu_stall", last_stall, 1);
        chk("lu_bubble", io.EX_Valid, 0);
        chk("lu_cnt", io.BubbleCnt, 1);
        step();
        chk("lu_retry_valid", io.EX_Valid, 1);
        chk("lu_retry_wr", io.EX_Wr, 9);

        // WB bypass at capture, and no bypass for index 0.
        idle(); io.ID_Valid = 1; io.ID_Rs = 5; io.ID_RsVal = 32'h11; io.ID_Rt = 6;
        io.ID_RtVal = 32'h22; io.WB_RegWrite = 1; io.WB_Wr = 5; io.WB_Data = 32'hABCD;
        step();
        chk("byp_rs", io.EX_RsVal, 32'hABCD);
        chk("byp_rt_untouched", io.EX_RtVal, 32'h22);
        io.WB_Wr = 0; step();
        chk("byp_wr0", io.EX_RsVal, 32'h11);
        io.WB_Wr = 6; step();
        chk("byp_rt", io.EX_RtVal, 32'hABCD);

        // Hold for 3 cycles with a flush in the middle; WB hits EX_Rs on the last.
        idle(); io.ID_Valid = 1; io.ID_Rs = 3; io.ID_Rt = 4; io.ID_RsVal = 32'h3333;
        io.ID_RtVal = 32'h4444; io.ID_Wr = 7; io.ID_RegWrite = 1; io.ID_ALUFn = ALU_SUB;
        step();
        saved = m;
        for (int h = 1; h <= 3; h++) begin
            rand_inputs();
            io.Hold = 1; io.Flush = (h == 2);
            io.WB_RegWrite = (h == 3); io.WB_Wr = 3; io.WB_Data = 32'h5555AAAA;
            step();
            if (h < 3) chk("hold_keep", obs(), saved);
            else chk("hold_byp", io.EX_RsVal, 32'h5555AAAA);
        end
        chk("hold_stall", last_stall, 1);
        idle(); io.ID_Valid = 1; io.ID_RegWrite = 1; io.ID_Wr = 2; step();
        chk("hold_flush_bubble", io.EX_Valid, 0);
        step();
        chk("after_flush_valid", io.EX_Valid, 1);

        // Flush and load-use together: flush wins, no count, stall still up.
        load_in_ex(5'd8);
        dependent_add(5'd8); io.Flush = 1; step();
        chk("fl_lu_stall", last_stall, 1);
        chk("fl_lu_bubble", io.EX_Valid, 0);
        chk("fl_lu_cnt", io.BubbleCnt, 1);

        // Four more load-use events: 5 total, 2-bit counter pinned at 3.
        for (int k = 0; k < 4; k++) begin
            load_in_ex(5'd12);
            dependent_add(5'd12); step();
        end
        chk("sat_w16", io.BubbleCnt, 5);
        chk("sat_w2", io_s.BubbleCnt, 3);

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        // Async reset mid-stream with a pending flush.
        rand_inputs(); io.Hold = 1; io.Flush = 1; step();
        rst_n = 0;
        #1;
        chk("rst_mid_ex", obs(), ex_t'(0));
        chk("rst_mid_cnt", io.BubbleCnt, 0);
        chk("rst_mid_cnt_w2", io_s.BubbleCnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(); io.ID_Valid = 1; io.ID_Wr = 4; io.ID_RegWrite = 1; step();
        chk("rst_fp_clear", io.EX_Valid, 1);

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
